// File: rtl/udp_tx_initiator.sv
// Active-side UDP traffic source: resolves the peer MAC through an ARP request,
// then launches fixed-size UDP frames carrying a {frame count, word index} pattern.
// All logic lives in the gmii_rx_clk domain.

module udp_tx_initiator #(
    parameter logic [31:0] DES_IP      = 32'hC0A8_0166,
    parameter logic [15:0] PKT_BYTES   = 16'd64,
    parameter logic [31:0] GAP_CYCLES  = 32'd125_000,
    parameter logic [31:0] ARP_TIMEOUT = 32'd125_000_000,
    parameter logic [3:0]  ARP_RETRY   = 4'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    // ARP receive side
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    // ARP transmit side
    input  logic        arp_tx_done,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    // UDP transmit side
    input  logic        udp_tx_req,
    input  logic        udp_tx_done,
    output logic        udp_tx_start_en,
    output logic [15:0] udp_tx_byte_num,
    output logic [31:0] udp_tx_data,
    // Status
    output logic [47:0] peer_mac,
    output logic [31:0] peer_ip,
    output logic        peer_valid,
    output logic        arp_fail,
    output logic [31:0] pkt_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StArpReq,
        StArpTxw,
        StArpWait,
        StGap,
        StUdpStart,
        StUdpWait,
        StFail
    } state_e;

    // Zero-length gap / timeout degrade to a single cycle instead of wrapping.
    localparam logic [31:0] GapLast = (GAP_CYCLES == 32'd0) ? 32'd0 : GAP_CYCLES - 32'd1;
    localparam logic [31:0] TmoLast = (ARP_TIMEOUT == 32'd0) ? 32'd0 : ARP_TIMEOUT - 32'd1;

    state_e      state_q, state_d;
    logic [3:0]  retry_cnt_q, retry_cnt_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [47:0] peer_mac_q, peer_mac_d;
    logic [31:0] peer_ip_q, peer_ip_d;
    logic        peer_valid_q, peer_valid_d;
    logic [31:0] tx_data_q, tx_data_d;

    logic        reply_match;
    logic [4:0]  retry_next;

    // Only an ARP reply from the target address resolves the peer.
    assign reply_match = arp_rx_done & arp_rx_type & (src_ip == DES_IP);
    // One bit wider so the attempt compare cannot overflow.
    assign retry_next  = {1'b0, retry_cnt_q} + 5'd1;

    // Next-state logic, datapath updates and strobe outputs.
    always_comb begin
        state_d         = state_q;
        retry_cnt_d     = retry_cnt_q;
        tmo_cnt_d       = tmo_cnt_q;
        gap_cnt_d       = gap_cnt_q;
        word_idx_d      = word_idx_q;
        pkt_cnt_d       = pkt_cnt_q;
        peer_mac_d      = peer_mac_q;
        peer_ip_d       = peer_ip_q;
        peer_valid_d    = peer_valid_q;
        tx_data_d       = tx_data_q;
        arp_tx_en       = 1'b0;
        udp_tx_start_en = 1'b0;
        arp_fail        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    if (peer_valid_q) begin
                        state_d   = StGap;
                        gap_cnt_d = 32'd0;
                    end else begin
                        state_d     = StArpReq;
                        retry_cnt_d = 4'd0;
                    end
                end
            end

            StArpReq: begin
                arp_tx_en = 1'b1;
                state_d   = StArpTxw;
            end

            StArpTxw: begin
                if (arp_tx_done) begin
                    state_d   = StArpWait;
                    tmo_cnt_d = 32'd0;
                end
            end

            StArpWait: begin
                // A matching reply takes priority over a simultaneous timeout.
                if (reply_match) begin
                    peer_mac_d   = src_mac;
                    peer_ip_d    = src_ip;
                    peer_valid_d = 1'b1;
                    gap_cnt_d    = 32'd0;
                    state_d      = StGap;
                end else if (tmo_cnt_q == TmoLast) begin
                    retry_cnt_d = retry_next[3:0];
                    if (retry_next < {1'b0, ARP_RETRY}) begin
                        state_d = StArpReq;
                    end else begin
                        state_d = StFail;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
            end

            StFail: begin
                arp_fail = 1'b1;
                if (!enable) begin
                    state_d = StIdle;
                end
            end

            StGap: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (gap_cnt_q == GapLast) begin
                    state_d = StUdpStart;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end

            StUdpStart: begin
                udp_tx_start_en = 1'b1;
                word_idx_d      = 16'd0;
                state_d         = StUdpWait;
            end

            StUdpWait: begin
                // Data appears the cycle after req, like a normal-mode FIFO read.
                if (udp_tx_req) begin
                    tx_data_d  = {pkt_cnt_q[15:0], word_idx_q};
                    word_idx_d = word_idx_q + 16'd1;
                end
                // The frame always completes, even if enable dropped meanwhile.
                if (udp_tx_done) begin
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                    gap_cnt_d = 32'd0;
                    state_d   = StGap;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            retry_cnt_q  <= 4'd0;
            tmo_cnt_q    <= 32'd0;
            gap_cnt_q    <= 32'd0;
            word_idx_q   <= 16'd0;
            pkt_cnt_q    <= 32'd0;
            peer_mac_q   <= 48'd0;
            peer_ip_q    <= 32'd0;
            peer_valid_q <= 1'b0;
            tx_data_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            retry_cnt_q  <= retry_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            word_idx_q   <= word_idx_d;
            pkt_cnt_q    <= pkt_cnt_d;
            peer_mac_q   <= peer_mac_d;
            peer_ip_q    <= peer_ip_d;
            peer_valid_q <= peer_valid_d;
            tx_data_q    <= tx_data_d;
        end
    end

    assign arp_tx_type     = 1'b0;
    assign udp_tx_byte_num = PKT_BYTES;
    assign udp_tx_data     = tx_data_q;
    assign peer_mac        = peer_mac_q;
    assign peer_ip         = peer_ip_q;
    assign peer_valid      = peer_valid_q;
    assign pkt_cnt         = pkt_cnt_q;

endmodule

// File: tb/tb_udp_tx_initiator.sv
// Bench for udp_tx_initiator: directed stimulus pushes expected pulses and data
// words into queues; a negedge monitor pops and compares whenever the DUT emits.

module tb_udp_tx_initiator;

    localparam logic [31:0] DES_IP   = 32'hC0A8_0166;
    localparam logic [31:0] OTHER_IP = 32'hC0A8_0165;
    localparam logic [47:0] PEER_MAC = 48'hAABB_CCDD_EEFF;
    localparam int          GAP      = 10;
    localparam int          TMO      = 100;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic        arp_tx_done;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic        udp_tx_req;
    logic        udp_tx_done;
    logic        udp_tx_start_en;
    logic [15:0] udp_tx_byte_num;
    logic [31:0] udp_tx_data;
    logic [47:0] peer_mac;
    logic [31:0] peer_ip;
    logic        peer_valid;
    logic        arp_fail;
    logic [31:0] pkt_cnt;

    udp_tx_initiator #(
        .DES_IP     (DES_IP),
        .PKT_BYTES  (16'd16),
        .GAP_CYCLES (32'd10),
        .ARP_TIMEOUT(32'd100),
        .ARP_RETRY  (4'd3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .arp_rx_done    (arp_rx_done),
        .arp_rx_type    (arp_rx_type),
        .src_mac        (src_mac),
        .src_ip         (src_ip),
        .arp_tx_done    (arp_tx_done),
        .arp_tx_en      (arp_tx_en),
        .arp_tx_type    (arp_tx_type),
        .udp_tx_req     (udp_tx_req),
        .udp_tx_done    (udp_tx_done),
        .udp_tx_start_en(udp_tx_start_en),
        .udp_tx_byte_num(udp_tx_byte_num),
        .udp_tx_data    (udp_tx_data),
        .peer_mac       (peer_mac),
        .peer_ip        (peer_ip),
        .peer_valid     (peer_valid),
        .arp_fail       (arp_fail),
        .pkt_cnt        (pkt_cnt)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        req_prev = 1'b0;

    // Expected cycle of each pulse (-1 = any cycle) and expected data words.
    int          exp_arp[$];
    int          exp_start[$];
    logic [31:0] exp_data[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and the req value the DUT saw at this edge.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        req_prev <= udp_tx_req;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: consumes scoreboard entries as the DUT presents outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (arp_tx_en) begin
                chk("arp_tx_type", {63'd0, arp_tx_type}, 64'd0);
                if (exp_arp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL arp_tx_en: unexpected pulse at cycle %0d, none expected", cyc);
                end else begin
                    int e;
                    e = exp_arp.pop_front();
                    if (e >= 0) chk("arp_tx_en cycle", 64'(cyc), 64'(e));
                    else checks++;
                end
            end
            if (udp_tx_start_en) begin
                if (exp_start.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL udp_tx_start_en: unexpected pulse at cycle %0d, none expected",
                             cyc);
                end else begin
                    int e;
                    e = exp_start.pop_front();
                    if (e >= 0) chk("udp_tx_start_en cycle", 64'(cyc), 64'(e));
                    else checks++;
                end
            end
            if (req_prev) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL udp_tx_data: got %0h with no expected word", udp_tx_data);
                end else begin
                    chk("udp_tx_data", {32'd0, udp_tx_data}, {32'd0, exp_data.pop_front()});
                end
            end
        end
    end

    // Hard stop if the directed sequence ever wedges.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for arp_tx_en (which=0) or udp_tx_start_en (which=1), bounded.
    task automatic wait_pulse(input int which, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            seen = (which == 0) ? arp_tx_en : udp_tx_start_en;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_pulse %0d: got no pulse within %0d cycles, required one",
                     which, limit);
        end
    endtask

    // Acknowledge an ARP request once the DUT is waiting for tx_done.
    task automatic ack_arp(output int done_cyc);
        tick();
        arp_tx_done = 1'b1;
        done_cyc    = cyc;
        tick();
        arp_tx_done = 1'b0;
    endtask

    task automatic arp_rx(input logic typ, input logic [31:0] ip, input logic [47:0] mac);
        arp_rx_done = 1'b1;
        arp_rx_type = typ;
        src_ip      = ip;
        src_mac     = mac;
    endtask

    task automatic udp_done(input bit expect_next);
        udp_tx_done = 1'b1;
        if (expect_next) exp_start.push_back(cyc + 1 + GAP);
        tick();
        udp_tx_done = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " pkt_cnt"}, {32'd0, pkt_cnt}, 64'd0);
        chk({tag, " peer_valid"}, {63'd0, peer_valid}, 64'd0);
        chk({tag, " peer_mac"}, {16'd0, peer_mac}, 64'd0);
        chk({tag, " peer_ip"}, {32'd0, peer_ip}, 64'd0);
        chk({tag, " arp_fail"}, {63'd0, arp_fail}, 64'd0);
        chk({tag, " udp_tx_data"}, {32'd0, udp_tx_data}, 64'd0);
        chk({tag, " udp_tx_byte_num"}, {48'd0, udp_tx_byte_num}, 64'd16);
        chk({tag, " arp_tx_en"}, {63'd0, arp_tx_en}, 64'd0);
        chk({tag, " udp_tx_start_en"}, {63'd0, udp_tx_start_en}, 64'd0);
    endtask

    initial begin
        int d;
        rst_n       = 1'b0;
        enable      = 1'b0;
        arp_rx_done = 1'b0;
        arp_rx_type = 1'b0;
        src_mac     = 48'd0;
        src_ip      = 32'd0;
        arp_tx_done = 1'b0;
        udp_tx_req  = 1'b0;
        udp_tx_done = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // 1: ARP resolve, then first frame start after the gap.
        enable = 1'b1;
        exp_arp.push_back(cyc + 1);
        wait_pulse(0, 20);
        ack_arp(d);
        repeat (5) tick();
        arp_rx(1'b1, DES_IP, PEER_MAC);
        exp_start.push_back(cyc + 1 + GAP);
        tick();
        arp_rx_done = 1'b0;
        chk("t1 peer_valid", {63'd0, peer_valid}, 64'd1);
        chk("t1 peer_mac", {16'd0, peer_mac}, {16'd0, PEER_MAC});
        chk("t1 peer_ip", {32'd0, peer_ip}, {32'd0, DES_IP});
        wait_pulse(1, GAP + 20);

        // 2: four payload words, then the next frame starts at word 00010000.
        tick();
        for (int i = 0; i < 4; i++) begin
            udp_tx_req = 1'b1;
            exp_data.push_back({16'h0000, 16'(i)});
            tick();
        end
        udp_tx_req = 1'b0;
        tick();
        udp_done(1'b1);
        chk("t2 pkt_cnt", {32'd0, pkt_cnt}, 64'd1);
        wait_pulse(1, GAP + 20);
        tick();
        // Extra requests past PKT_BYTES/4 keep counting.
        for (int i = 0; i < 5; i++) begin
            udp_tx_req = 1'b1;
            exp_data.push_back({16'h0001, 16'(i)});
            tick();
        end
        udp_tx_req = 1'b0;

        // 5: disable mid-frame; done still counts, no new frame, re-enable skips ARP.
        enable = 1'b0;
        tick();
        udp_done(1'b0);
        chk("t5 pkt_cnt", {32'd0, pkt_cnt}, 64'd2);
        repeat (GAP + 5) tick();
        chk("t5 peer_valid kept", {63'd0, peer_valid}, 64'd1);
        enable = 1'b1;
        exp_start.push_back(cyc + 1 + GAP);
        wait_pulse(1, GAP + 20);

        // 6: reset mid-frame, then a fresh ARP request.
        tick();
        for (int i = 0; i < 2; i++) begin
            udp_tx_req = 1'b1;
            exp_data.push_back({16'h0002, 16'(i)});
            tick();
        end
        udp_tx_req = 1'b0;
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("t6");
        rst_n = 1'b1;
        exp_arp.push_back(cyc + 1);
        wait_pulse(0, 20);

        // 3: no reply; three attempts spaced tx_done + TMO, then arp_fail.
        for (int a = 0; a < 3; a++) begin
            ack_arp(d);
            if (a < 2) begin
                exp_arp.push_back(d + TMO + 1);
                wait_pulse(0, TMO + 20);
            end
        end
        while (cyc < d + TMO) tick();
        chk("t3 arp_fail before timeout", {63'd0, arp_fail}, 64'd0);
        tick();
        chk("t3 arp_fail", {63'd0, arp_fail}, 64'd1);
        repeat (20) tick();
        chk("t3 arp_fail sticky", {63'd0, arp_fail}, 64'd1);
        enable = 1'b0;
        tick();
        chk("t3 arp_fail cleared", {63'd0, arp_fail}, 64'd0);
        repeat (5) tick();

        // 4: wrong-IP reply and a request are ignored; timer keeps running.
        enable = 1'b1;
        exp_arp.push_back(cyc + 1);
        wait_pulse(0, 20);
        ack_arp(d);
        exp_arp.push_back(d + TMO + 1);
        repeat (3) tick();
        arp_rx(1'b1, OTHER_IP, 48'h1122_3344_5566);
        tick();
        arp_rx(1'b0, DES_IP, 48'h6655_4433_2211);
        tick();
        arp_rx_done = 1'b0;
        chk("t4 peer_valid", {63'd0, peer_valid}, 64'd0);
        wait_pulse(0, TMO + 20);

        // Matching reply in the same cycle as the timeout wins.
        ack_arp(d);
        while (cyc < d + TMO) tick();
        arp_rx(1'b1, DES_IP, PEER_MAC);
        exp_start.push_back(cyc + 1 + GAP);
        tick();
        arp_rx_done = 1'b0;
        chk("t4 peer_valid on timeout edge", {63'd0, peer_valid}, 64'd1);
        chk("t4 peer_mac", {16'd0, peer_mac}, {16'd0, PEER_MAC});
        chk("t4 arp_fail", {63'd0, arp_fail}, 64'd0);
        wait_pulse(1, GAP + 20);
        repeat (5) tick();

        chk("arp queue drained", 64'(exp_arp.size()), 64'd0);
        chk("start queue drained", 64'(exp_start.size()), 64'd0);
        chk("data queue drained", 64'(exp_data.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
